led_decoder_3to8: RTL and testbench
===================================

Name: led_decoder_3to8

Overview:
- Registered 3-to-8 line decoder with a 74x138-style three-pin enable and active-low outputs.
- Drives an 8-LED bank. Exactly one LED is lit, selected by a 3-bit switch code, only when the enable pattern is valid.
- Sits between board switch/enable inputs and LED pins. One clock domain; output is registered.

Parameters:
- None. Widths are fixed: select 3 bits, enable 3 bits, output 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low. Sampled on the rising edge of clk; rst=0 resets.
- enable  input  3  enable group {G1, G2A_n, G2B_n}. Valid only when enable == 3'b100.
- switch  input  3  binary select code, 0..7.
- led  output  8  registered decoder output, active-low. 0 = LED lit.

Behaviour:
- All state changes on posedge clk only. No combinational path from any input to led.
- Reset:
  - If rst==0 at a rising edge, led <= 8'hFF (all LEDs off).
  - Reset has priority over enable and switch.
  - Reset is synchronous: asserting rst between edges does not change led until the next rising edge.
- Normal operation (rst==1):
  - If enable == 3'b100: led <= 8'hFF with bit [switch] cleared to 0. Formally led <= ~(8'h01 << switch).
  - Any other enable value (including 3'b000, 3'b101, 3'b110, 3'b111, 3'b0xx): led <= 8'hFF.
  - Enable must match exactly; a partial match is a disable.
- Latency: one cycle. Inputs sampled at edge N appear on led after edge N.
- led holds its value between edges. No other internal state.
- Switch values are always in range 0..7, so wrap-around cannot occur.
- At most one led bit is 0 at any time.
- Mid-operation reset: the next edge with rst==0 forces 8'hFF. The first edge with rst==1 resumes decoding from the inputs present at that edge.
- Before the first reset edge, led is undefined. The design does not rely on a power-up initial value.

Optional Feature:
- Macro: LED_DECODER_ACTIVE_HIGH_EN.
- Undefined (default): behaviour exactly as above. Active-low outputs, reset value 8'hFF, disabled value 8'hFF.
- Defined: output polarity is inverted.
  - Active-low reset and disabled state drive led to 8'h00.
  - Valid enable drives led <= 8'h01 << switch.
  - Timing, latency and priority are unchanged.

Test Plan:
- rst=0 for 2 edges with enable=3'b100, switch=3 -> led=8'hFF after each edge. Then rst=1 -> next edge led=8'hF7.
- rst=1, enable=3'b100, sweep switch 0..7 one per cycle -> led follows one cycle later: FE, FD, FB, F7, EF, DF, BF, 7F.
- rst=1, switch=5, enable stepped through 000, 001, 010, 011, 101, 110, 111 -> led=8'hFF each cycle. Return to 100 -> led=8'hDF.
- Decoding with led=8'hBF (switch=6); pulse rst=0 for one edge while enable=100 -> led=8'hFF on that edge. Restores 8'hBF on the following edge.
- Change switch 2->4 mid-cycle, away from the edge -> led stays 8'hFB until the next rising edge, then becomes 8'hEF.
- Macro defined: reset -> 8'h00; enable=100, switch=7 -> 8'h80; enable=000 -> 8'h00.

Source files
------------

// File: rtl/led_decoder_3to8_if.sv
// Bus bundle for the registered 3-to-8 LED decoder: enable group, select code and LED pins.
// master drives enable/switch and observes led; slave is the decoder side.
interface led_decoder_3to8_if;
    logic [2:0] enable;
    logic [2:0] switch;
    logic [7:0] led;

    modport master (
        output enable,
        output switch,
        input  led
    );

    modport slave (
        input  enable,
        input  switch,
        output led
    );
endinterface

// File: rtl/led_decoder_3to8.sv
// Registered 74x138-style 3-to-8 decoder driving an LED bank, active-low outputs by default.
// Optional macro LED_DECODER_ACTIVE_HIGH_EN inverts output polarity (lit = 1, idle = 0).
module led_decoder_3to8 (
    input  logic                clk,
    input  logic                rst,
    led_decoder_3to8_if.slave   bus
);

`ifdef LED_DECODER_ACTIVE_HIGH_EN
    localparam logic [7:0] LED_IDLE = 8'h00;
`else
    localparam logic [7:0] LED_IDLE = 8'hFF;
`endif

    // G1 high with both G2 inputs low is the only pattern that enables decoding.
    localparam logic [2:0] ENABLE_VALID = 3'b100;

    logic [7:0] one_hot;
    logic       enable_ok;
    logic [7:0] led_d;
    logic [7:0] led_q;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign one_hot[gi] = (bus.switch == 3'(gi));
        end
    endgenerate

    assign enable_ok = (bus.enable == ENABLE_VALID);

    always_comb begin
        led_d = LED_IDLE;
        if (enable_ok) begin
`ifdef LED_DECODER_ACTIVE_HIGH_EN
            led_d = one_hot;
`else
            led_d = ~one_hot;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q <= LED_IDLE;
        end else begin
            led_q <= led_d;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_led_decoder_3to8.sv
// Scoreboard bench for led_decoder_3to8: expected LED words queued at drive time, popped after each edge.
module tb_led_decoder_3to8;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;

    led_decoder_3to8_if bus_if ();

    led_decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic r, input logic [2:0] en, input logic [2:0] sw);
        logic [7:0] lit;
        lit = 8'h01 << sw;
`ifdef LED_DECODER_ACTIVE_HIGH_EN
        if (!r || en != 3'b100) return 8'h00;
        return lit;
`else
        if (!r || en != 3'b100) return 8'hFF;
        return ~lit;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: led=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: led=%h", tag, got);
        end
    endtask

    // Drive one transaction between edges, then compare the registered result after the edge.
    task automatic step(input string tag, input logic r, input logic [2:0] en, input logic [2:0] sw);
        logic [7:0] exp;
        @(negedge clk);
        rst = r;
        bus_if.enable = en;
        bus_if.switch = sw;
        exp_q.push_back(model(r, en, sw));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, led=%h", tag, bus_if.led);
        end else begin
            exp = exp_q.pop_front();
            last_exp = exp;
            check(tag, bus_if.led, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_exp = 8'h00;
        rst = 1'b0;
        bus_if.enable = 3'b100;
        bus_if.switch = 3'd3;

        step("reset_edge1", 1'b0, 3'b100, 3'd3);
        step("reset_edge2", 1'b0, 3'b100, 3'd3);
        step("reset_release", 1'b1, 3'b100, 3'd3);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("sweep_sw%0d", i), 1'b1, 3'b100, 3'(i));
        end

        for (int e = 0; e < 8; e++) begin
            if (e != 4) step($sformatf("enable_%03b", 3'(e)), 1'b1, 3'(e), 3'd5);
        end
        step("enable_valid_again", 1'b1, 3'b100, 3'd5);

        step("pre_pulse", 1'b1, 3'b100, 3'd6);
        step("reset_pulse", 1'b0, 3'b100, 3'd6);
        step("post_pulse", 1'b1, 3'b100, 3'd6);

        // Input change well away from the edge must not reach led until the next rising edge.
        step("mid_base", 1'b1, 3'b100, 3'd2);
        @(negedge clk);
        bus_if.switch = 3'd4;
        #2;
        check("mid_hold", bus_if.led, last_exp);
        exp_q.push_back(model(1'b1, 3'b100, 3'd4));
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) check("mid_update", bus_if.led, exp_q.pop_front());

        // Asserting reset between edges leaves led alone until the edge.
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("async_rst_ignored", bus_if.led, model(1'b1, 3'b100, 3'd4));
        step("rst_takes_effect", 1'b0, 3'b100, 3'd4);

        for (int k = 0; k < 20; k++) begin
            step($sformatf("rand%0d", k), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
        end

`ifdef LED_DECODER_ACTIVE_HIGH_EN
        step("ah_reset", 1'b0, 3'b100, 3'd7);
        step("ah_sw7", 1'b1, 3'b100, 3'd7);
        step("ah_disabled", 1'b1, 3'b000, 3'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
